instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (bits [1:0] SHALL be treated as 0).
REQ-002 The module SHALL have parameter CACHE_LINES, default 16, meaning the number of direct-mapped one-word cache lines (power of 2, 4..64).
REQ-003 clock  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 stall  input  1  when high, the PC SHALL be held (downstream hazard).
REQ-006 branch_taken  input  1  one-cycle redirect request from a later stage.
REQ-007 branch_target  input  32  redirect address; bits [1:0] SHALL be ignored.
REQ-008 mem_read  output  1  refill request to instruction memory.
REQ-009 mem_address  output  32  word-aligned refill address.
REQ-010 mem_ready  input  1  memory acknowledge; mem_data valid in the same cycle.
REQ-011 mem_data  input  32  refill word.
REQ-012 instruction  output  32  fetched word, feeds the IF/ID register.
REQ-013 next_PC  output  32  PC+4 of the fetched word, feeds the IF/ID register.
REQ-014 hit  output  1  high when instruction/next_PC are valid this cycle; feeds the IF/ID register hit input.

Function
REQ-015 Cache: index = PC[log2(CACHE_LINES)+1:2], tag = remaining PC upper bits; one valid bit per line; lookup SHALL be combinational on the current PC.
REQ-016 FSM states SHALL be IDLE and FETCH only.
REQ-017 IDLE, lookup hit: hit=1, instruction=cached word, next_PC=PC+4 (mod 2^32, so 32'hFFFF_FFFC yields 0).
REQ-018 IDLE, lookup miss: hit=0, instruction=32'h0 (NOP), next_PC=PC+4; FSM SHALL enter FETCH on the next edge; PC SHALL not change.
REQ-019 IDLE, hit, stall=0, branch_taken=0: PC SHALL load PC+4.
REQ-020 IDLE, branch_taken=1: PC SHALL load {branch_target[31:2],2'b00} regardless of stall or hit (branch overrides stall).
REQ-021 IDLE, hit, stall=1, branch_taken=0: PC and outputs SHALL hold.
REQ-022 FETCH: mem_read=1, mem_address={PC[31:2],2'b00} held stable until mem_ready; hit=0, instruction=0.
REQ-023 FETCH with mem_ready=1: line[index] SHALL be written with mem_data, tag updated, valid set; FSM SHALL return to IDLE; mem_read SHALL drop on the same edge.
REQ-024 branch_taken during FETCH SHALL set a redirect_pending flag and capture the target; the refill SHALL complete unchanged; on the mem_ready edge PC SHALL load the captured target and the flag SHALL clear.
REQ-025 branch_taken coincident with mem_ready SHALL behave as REQ-024 in one edge (line filled, PC loads branch_target, IDLE).
REQ-026 A second branch_taken while redirect_pending SHALL overwrite the captured target (latest wins).
REQ-027 Minimum miss penalty: miss detected in cycle N, mem_read high in N+1, mem_ready in N+1 gives hit=1 in N+2.
REQ-028 mem_read SHALL never be asserted in IDLE; stall SHALL have no effect in FETCH.

Reset
REQ-029 While reset_n=0: PC=RESET_PC, FSM=IDLE, all valid bits=0, redirect_pending=0, mem_read=0; consequently hit=0, instruction=0, next_PC=RESET_PC+4, mem_address=RESET_PC.
REQ-030 Reset asserted during FETCH SHALL abort the refill immediately (mem_read low asynchronously); no line SHALL be written.
REQ-031 Cache data and tag arrays need not be reset; only valid bits.

Verification
REQ-032 Cold start: RESET_PC=0, release reset, mem_ready one cycle after mem_read -> mem_read=1 with mem_address=0, then hit=1, instruction=mem_data, next_PC=4.
REQ-033 Sequential hits: preload 0,4,8 via misses, replay from 0 with stall=0 -> hit=1 each cycle, next_PC 4,8,12.
REQ-034 Stall: hit at PC=8, stall=1 for 3 cycles -> PC, instruction, next_PC=12 constant, hit=1; branch_taken=1 target 32'h40 during stall -> PC=32'h40 next edge.
REQ-035 Branch during miss: miss at PC=32'h10, branch_taken target 32'h23 while mem_ready held low 4 cycles -> refill completes, line 4 valid, then PC=32'h20.
REQ-036 Reset mid-FETCH: reset_n low while mem_read=1 -> mem_read=0 at once, hit=0, re-access to same PC misses again.
REQ-037 Wrap/alias: PC=32'hFFFF_FFFC hit -> next_PC=0; PC 0 and 32'h40 (same index, CACHE_LINES=16) alternate -> each access misses and evicts the other.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, direct-mapped one-word-per-line
// instruction cache with combinational lookup, and a two-state refill FSM
// that talks to instruction memory over a simple read/ready handshake.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned CACHE_LINES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        mem_read,
    output logic [31:0] mem_address,
    input  logic        mem_ready,
    input  logic [31:0] mem_data,
    output logic [31:0] instruction,
    output logic [31:0] next_PC,
    output logic        hit
);

    localparam int unsigned IDX_W    = $clog2(CACHE_LINES);
    localparam int unsigned TAG_W    = 30 - IDX_W;
    localparam logic [31:0] PC_RESET = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t                   state_q;
    logic [31:0]              pc_q;
    logic [CACHE_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]         tag_q  [CACHE_LINES];
    logic [31:0]              data_q [CACHE_LINES];
    logic                     redirect_pending_q;
    logic [31:0]              redirect_target_q;
    logic                     mem_read_q;

    logic [IDX_W-1:0]         pc_idx;
    logic [TAG_W-1:0]         pc_tag;
    logic                     lookup_hit;
    logic                     fill_en;
    logic [31:0]              target_aligned;

    // Cache lookup on the current PC and derived fetch outputs.
    always_comb begin
        pc_idx         = pc_q[IDX_W+1:2];
        pc_tag         = pc_q[31:IDX_W+2];
        lookup_hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
        fill_en        = (state_q == S_FETCH) && mem_ready;
        target_aligned = branch_target & 32'hFFFF_FFFC;

        hit            = (state_q == S_IDLE) && lookup_hit;
        instruction    = hit ? data_q[pc_idx] : '0;
        next_PC        = pc_q + 32'd4;
        mem_read       = mem_read_q;
        mem_address    = pc_q & 32'hFFFF_FFFC;
    end

    // PC, valid bits, redirect capture and the IDLE/FETCH refill sequencer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            pc_q               <= PC_RESET;
            valid_q            <= '0;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= '0;
            mem_read_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // A redirect wins over both stall and a pending miss:
                    // the missing word is no longer wanted.
                    if (branch_taken) begin
                        pc_q <= target_aligned;
                    end else if (!lookup_hit) begin
                        state_q    <= S_FETCH;
                        mem_read_q <= 1'b1;
                    end else if (!stall) begin
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        valid_q[pc_idx]    <= 1'b1;
                        state_q            <= S_IDLE;
                        mem_read_q         <= 1'b0;
                        redirect_pending_q <= 1'b0;
                        if (branch_taken) begin
                            pc_q <= target_aligned;
                        end else if (redirect_pending_q) begin
                            pc_q <= redirect_target_q;
                        end
                    end else if (branch_taken) begin
                        // Refill runs to completion; latest redirect wins.
                        redirect_pending_q <= 1'b1;
                        redirect_target_q  <= target_aligned;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    mem_read_q <= 1'b0;
                end
            endcase
        end
    end

    // Line data and tag storage; written only when a refill completes.
    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_q[pc_idx] <= mem_data;
            tag_q[pc_idx]  <= pc_tag;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a refill scoreboard.
module tb_instruction_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        mem_read;
    logic [31:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_data;
    logic [31:0] instruction;
    logic [31:0] next_PC;
    logic        hit;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } exp_t;

    exp_t sb[$];

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .CACHE_LINES(16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_ready    (mem_ready),
        .mem_data     (mem_data),
        .instruction  (instruction),
        .next_PC      (next_PC),
        .hit          (hit)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic sb_push(input logic [31:0] pc);
        exp_t e;
        e.instr = mem_model(pc);
        e.npc   = pc + 32'd4;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, {31'b0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_hit"},   {31'b0, hit}, 32'd1);
            chk({tag, "_instr"}, instruction, e.instr);
            chk({tag, "_npc"},   next_PC,     e.npc);
        end
    endtask

    task automatic wait_mem_read(input string tag, input int max_cycles);
        int n = 0;
        while (mem_read !== 1'b1 && n < max_cycles) begin
            cyc();
            n++;
        end
        chk({tag, "_memrd"}, {31'b0, mem_read}, 32'd1);
    endtask

    // Serve one refill for address pc after lat extra wait cycles.
    task automatic refill(input string tag, input logic [31:0] pc, input int lat);
        wait_mem_read(tag, 4);
        chk({tag, "_addr"}, mem_address, pc);
        for (int i = 0; i < lat; i++) begin
            cyc();
            chk({tag, "_rd_hold"}, {31'b0, mem_read}, 32'd1);
            chk({tag, "_addr_hold"}, mem_address, pc);
        end
        mem_ready = 1'b1;
        mem_data  = mem_model(pc);
        sb_push(pc);
        cyc();
        mem_ready = 1'b0;
        mem_data  = '0;
        settle();
        chk({tag, "_rd_drop"}, {31'b0, mem_read}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        mem_ready     = 1'b0;
        mem_data      = '0;

        // Reset state
        #12;
        chk("rst_memrd", {31'b0, mem_read}, 32'd0);
        chk("rst_hit",   {31'b0, hit}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_npc",   next_PC, 32'd4);
        chk("rst_addr",  mem_address, 32'd0);
        cyc();
        reset_n = 1'b1;
        settle();

        // Cold start and preload of 0, 4, 8
        chk("cold_miss_hit",   {31'b0, hit}, 32'd0);
        chk("cold_miss_instr", instruction, 32'd0);
        refill("cold", 32'h0, 1);
        sb_check("cold");
        cyc(); settle();
        chk("pc4_miss", {31'b0, hit}, 32'd0);
        chk("pc4_npc", next_PC, 32'd8);
        refill("pc4", 32'h4, 0);
        sb_check("pc4");
        cyc(); settle();
        refill("pc8", 32'h8, 1);
        sb_check("pc8");

        // Sequential replay from 0
        branch_taken = 1'b1; branch_target = 32'h0;
        cyc(); branch_taken = 1'b0; settle();
        chk("seq0_hit", {31'b0, hit}, 32'd1);
        chk("seq0_instr", instruction, mem_model(32'h0));
        chk("seq0_npc", next_PC, 32'd4);
        cyc(); settle();
        chk("seq4_hit", {31'b0, hit}, 32'd1);
        chk("seq4_instr", instruction, mem_model(32'h4));
        chk("seq4_npc", next_PC, 32'd8);
        cyc(); settle();
        chk("seq8_hit", {31'b0, hit}, 32'd1);
        chk("seq8_instr", instruction, mem_model(32'h8));
        chk("seq8_npc", next_PC, 32'd12);

        // Stall holds at PC 8, branch overrides stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); settle();
            chk("stall_hit", {31'b0, hit}, 32'd1);
            chk("stall_instr", instruction, mem_model(32'h8));
            chk("stall_npc", next_PC, 32'd12);
        end
        branch_taken = 1'b1; branch_target = 32'h40;
        cyc(); branch_taken = 1'b0; stall = 1'b0; settle();
        chk("stall_br_npc", next_PC, 32'h44);
        chk("stall_br_miss", {31'b0, hit}, 32'd0);

        // Aliasing lines 0 and 0x40
        refill("alias40", 32'h40, 0);
        sb_check("alias40");
        branch_taken = 1'b1; branch_target = 32'h0;
        cyc(); branch_taken = 1'b0; settle();
        chk("alias0_miss", {31'b0, hit}, 32'd0);
        chk("alias0_npc", next_PC, 32'd4);
        refill("alias0", 32'h0, 0);
        sb_check("alias0");
        branch_taken = 1'b1; branch_target = 32'h40;
        cyc(); branch_taken = 1'b0; settle();
        chk("alias40_evicted", {31'b0, hit}, 32'd0);
        chk("alias40_npc", next_PC, 32'h44);

        // Wrap at top of address space; low target bits ignored
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
        cyc(); branch_taken = 1'b0; settle();
        chk("wrap_miss", {31'b0, hit}, 32'd0);
        chk("wrap_miss_npc", next_PC, 32'd0);
        chk("wrap_addr", mem_address, 32'hFFFF_FFFC);
        refill("wrap", 32'hFFFF_FFFC, 1);
        sb_check("wrap");

        // Branches during a long refill; stall ignored in FETCH
        branch_taken = 1'b1; branch_target = 32'h10;
        cyc(); branch_taken = 1'b0; settle();
        chk("redir_miss", {31'b0, hit}, 32'd0);
        cyc(); settle();
        chk("redir_memrd", {31'b0, mem_read}, 32'd1);
        stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h80;
        cyc(); branch_taken = 1'b0; settle();
        chk("redir_hold1_rd", {31'b0, mem_read}, 32'd1);
        chk("redir_hold1_addr", mem_address, 32'h10);
        cyc(); settle();
        chk("redir_hold2_addr", mem_address, 32'h10);
        branch_taken = 1'b1; branch_target = 32'h23;
        cyc(); branch_taken = 1'b0; stall = 1'b0; settle();
        chk("redir_hold3_rd", {31'b0, mem_read}, 32'd1);
        chk("redir_hold3_hit", {31'b0, hit}, 32'd0);
        mem_ready = 1'b1; mem_data = mem_model(32'h10); sb_push(32'h10);
        cyc(); mem_ready = 1'b0; mem_data = '0; settle();
        chk("redir_rd_drop", {31'b0, mem_read}, 32'd0);
        chk("redir_pc", next_PC, 32'h24);
        chk("redir_newpc_miss", {31'b0, hit}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h10;
        cyc(); branch_taken = 1'b0; settle();
        sb_check("line4");

        // Branch coincident with mem_ready
        branch_taken = 1'b1; branch_target = 32'h30;
        cyc(); branch_taken = 1'b0; settle();
        chk("coinc_miss", {31'b0, hit}, 32'd0);
        chk("coinc_miss_npc", next_PC, 32'h34);
        cyc(); settle();
        chk("coinc_memrd", {31'b0, mem_read}, 32'd1);
        mem_ready = 1'b1; mem_data = mem_model(32'h30); sb_push(32'h30);
        branch_taken = 1'b1; branch_target = 32'h4;
        cyc(); mem_ready = 1'b0; mem_data = '0; branch_taken = 1'b0; settle();
        chk("coinc_rd_drop", {31'b0, mem_read}, 32'd0);
        chk("coinc_hit", {31'b0, hit}, 32'd1);
        chk("coinc_instr", instruction, mem_model(32'h4));
        chk("coinc_npc", next_PC, 32'd8);
        branch_taken = 1'b1; branch_target = 32'h30;
        cyc(); branch_taken = 1'b0; settle();
        sb_check("coinc_fill");

        // Reset asserted mid-refill
        branch_taken = 1'b1; branch_target = 32'h34;
        cyc(); branch_taken = 1'b0; settle();
        chk("rstf_miss", {31'b0, hit}, 32'd0);
        cyc(); settle();
        chk("rstf_memrd", {31'b0, mem_read}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstf_rd_async", {31'b0, mem_read}, 32'd0);
        chk("rstf_hit", {31'b0, hit}, 32'd0);
        chk("rstf_instr", instruction, 32'd0);
        chk("rstf_addr", mem_address, 32'd0);
        cyc(); cyc();
        reset_n = 1'b1;
        settle();
        chk("rstf_pc0_miss", {31'b0, hit}, 32'd0);
        branch_taken = 1'b1; branch_target = 32'h34;
        cyc(); branch_taken = 1'b0; settle();
        chk("rstf_reaccess_miss", {31'b0, hit}, 32'd0);
        chk("rstf_reaccess_npc", next_PC, 32'h38);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
